// File: rtl/spi_ram_pkg.sv
// Shared types for the 10-bit RAM command interface: beat opcodes,
// command-master FSM states and the command beat width.
package spi_ram_pkg;

  localparam int CMD_W = 10;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_CMD  = 3'd4,
    ST_RD_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/ram_cmd_timer.sv
// Read-wait cycle counter. While enabled it counts the cycles spent waiting;
// expired is high during the RD_TIMEOUT-th enabled cycle since the last clear.
module ram_cmd_timer #(
  parameter int RD_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Counter holds at the limit so it can never wrap if the wait is extended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && (cnt == CW'(RD_TIMEOUT - 1));

endmodule

// File: rtl/ram_cmd_master.sv
// Initiator for the 10-bit RAM command interface. A host request becomes two
// command beats (write: {00,addr},{01,data}; read: {10,addr},{11,00}); reads
// then wait for tx_valid or a timeout and return one rsp_valid pulse.
// Optional feature macro: RAM_CMD_MASTER_ERR_CNT_EN adds err_count[7:0].
//
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// req_ready is high only in IDLE and does not depend on req_valid. rsp_valid
// is a one-cycle pulse with no backpressure; rsp_timeout/rsp_rdata qualify it.
module ram_cmd_master
  import spi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [7:0]       req_addr,
  input  logic [7:0]       req_wdata,
  output logic             rsp_valid,
  output logic [7:0]       rsp_rdata,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             rx_valid,
  output logic [CMD_W-1:0] din,
  input  logic             tx_valid,
`ifdef RAM_CMD_MASTER_ERR_CNT_EN
  output logic [7:0]       err_count,
`endif
  input  logic [7:0]       dout
);

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            addr_pay;
  logic [7:0]            data_pay;
  logic                  accept;
  logic                  in_wait;
  logic                  expired;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign in_wait = (state_q == ST_RD_WAIT);

  ram_cmd_timer #(.RD_TIMEOUT(RD_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (expired)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request fields are captured on the accept edge so the host may change them afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr[ADDR_WIDTH-1:0];
      wdata_q <= req_wdata[DATA_WIDTH-1:0];
    end
  end

  // Zero-extend narrow address/data into the 8-bit beat payload.
  always_comb begin
    addr_pay = '0;
    data_pay = '0;
    addr_pay[ADDR_WIDTH-1:0] = addr_q;
    data_pay[DATA_WIDTH-1:0] = wdata_q;
  end

  // Next state and command beat outputs; din is forced to zero whenever no beat is driven.
  always_comb begin
    state_d   = state_q;
    rx_valid  = 1'b0;
    din       = '0;
    req_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_d = req_write ? ST_WR_ADDR : ST_RD_ADDR;
      end
      ST_WR_ADDR: begin
        rx_valid = 1'b1;
        din      = {OP_WR_ADDR, addr_pay};
        state_d  = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        rx_valid = 1'b1;
        din      = {OP_WR_DATA, data_pay};
        state_d  = ST_IDLE;
      end
      ST_RD_ADDR: begin
        rx_valid = 1'b1;
        din      = {OP_RD_ADDR, addr_pay};
        state_d  = ST_RD_CMD;
      end
      ST_RD_CMD: begin
        rx_valid = 1'b1;
        din      = {OP_RD_DATA, 8'h00};
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (tx_valid || expired) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response register: returned data takes priority over a timeout in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      if (in_wait && tx_valid) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= dout;
      end else if (in_wait && expired) begin
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
    end
  end

`ifdef RAM_CMD_MASTER_ERR_CNT_EN
  logic spurious;
  logic timeout_evt;

  assign spurious    = tx_valid && !in_wait;
  assign timeout_evt = in_wait && expired && !tx_valid;

  // Saturating error counter: at most one increment per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if ((spurious || timeout_evt) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_cmd_master.sv
// Directed bench for ram_cmd_master: reset, write/read sequences, read
// latency extremes, timeout, data-vs-timeout tie, spurious tx_valid,
// reset during a read and back-to-back requests.
module tb_ram_cmd_master;

  localparam int RD_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       busy;
  logic       rx_valid;
  logic [9:0] din;
  logic       tx_valid = 1'b0;
  logic [7:0] dout = 8'h00;
`ifdef RAM_CMD_MASTER_ERR_CNT_EN
  logic [7:0] err_count;
  int         exp_err = 0;
`endif

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  ram_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .rx_valid    (rx_valid),
    .din         (din),
    .tx_valid    (tx_valid),
`ifdef RAM_CMD_MASTER_ERR_CNT_EN
    .err_count   (err_count),
`endif
    .dout        (dout)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rx_valid !== 1'b0 || din !== 10'h000 ||
        rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b rx_valid=%b din=%h rsp=%b/%b/%h expected 1/0/0/000/0/0/00",
               req_ready, busy, rx_valid, din, rsp_valid, rsp_timeout, rsp_rdata);
    end
`ifdef RAM_CMD_MASTER_ERR_CNT_EN
    checks++;
    if (err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_err_count: got %h expected 00", err_count);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h3C; req_wdata = 8'hA5;
    step();
    // Change the request fields after accept: the beats must use the latched values.
    req_valid = 1'b0; req_addr = 8'hFF; req_wdata = 8'h00;
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h03C || req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_beat0: rx_valid=%b din=%h ready=%b busy=%b expected 1/03c/0/1",
               rx_valid, din, req_ready, busy);
    end
    step();
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h1A5) begin
      errors++;
      $display("FAIL wr_beat1: rx_valid=%b din=%h expected 1/1a5", rx_valid, din);
    end
    step();
    checks++;
    if (rx_valid !== 1'b0 || din !== 10'h000 || req_ready !== 1'b1 || busy !== 1'b0 ||
        rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: rx_valid=%b din=%h ready=%b busy=%b rsp_valid=%b expected 0/000/1/0/0",
               rx_valid, din, req_ready, busy, rsp_valid);
    end
  endtask

  // Issue a read; if give_tx the RAM answers in RD_WAIT cycle n (1-based), else never.
  task automatic test_read(input logic [7:0] addr, input logic [7:0] data,
                           input int n, input bit give_tx, input string name);
    logic [9:0] exp_beat;
    logic [7:0] exp_data;
    int         cyc;
    int         exp_cyc;
    bit         got;
    exp_beat = {2'b10, addr};
    exp_q.push_back(give_tx ? data : 8'h00);
    exp_cyc = give_tx ? (n + 3) : (RD_TIMEOUT + 3);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = 8'h5A;
    step();
    req_valid = 1'b0;
    cyc = 1;
    checks++;
    if (rx_valid !== 1'b1 || din !== exp_beat) begin
      errors++;
      $display("FAIL %s_addr_beat: rx_valid=%b din=%h expected 1/%h", name, rx_valid, din, exp_beat);
    end
    step();
    cyc = 2;
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h300) begin
      errors++;
      $display("FAIL %s_cmd_beat: rx_valid=%b din=%h expected 1/300", name, rx_valid, din);
    end
    got = 1'b0;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      tx_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
      end else if (give_tx && cyc == n + 2) begin
        tx_valid = 1'b1;
        dout = data;
      end
    end
    exp_data = exp_q.pop_front();
    checks++;
    if (!got || cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s_latency: rsp seen=%0d after %0d cycles expected 1 after %0d",
               name, got, cyc, exp_cyc);
    end
    checks++;
    if (rsp_rdata !== exp_data || rsp_timeout !== !give_tx || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_rsp: rdata=%h timeout=%b ready=%b expected %h/%b/1",
               name, rsp_rdata, rsp_timeout, req_ready, exp_data, !give_tx);
    end
`ifdef RAM_CMD_MASTER_ERR_CNT_EN
    if (!give_tx) exp_err++;
    checks++;
    if (err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL %s_err_count: got %h expected %h", name, err_count, 8'(exp_err));
    end
`endif
    step();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== exp_data) begin
      errors++;
      $display("FAIL %s_rsp_hold: valid=%b timeout=%b rdata=%h expected 0/0/%h",
               name, rsp_valid, rsp_timeout, rsp_rdata, exp_data);
    end
  endtask

  task automatic test_spurious();
    int rsp_seen;
    rsp_seen = 0;
    tx_valid = 1'b1; dout = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rsp_valid === 1'b1) rsp_seen++;
    end
    checks++;
    if (rsp_seen != 0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle: rsp_pulses=%0d ready=%b busy=%b expected 0/1/0", rsp_seen, req_ready, busy);
    end
    // Write with tx_valid held high throughout.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h81; req_wdata = 8'h42;
    step();
    req_valid = 1'b0;
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h081 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL spur_wr_beat0: rx_valid=%b din=%h rsp_valid=%b expected 1/081/0", rx_valid, din, rsp_valid);
    end
    step();
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h142 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL spur_wr_beat1: rx_valid=%b din=%h rsp_valid=%b expected 1/142/0", rx_valid, din, rsp_valid);
    end
    step();
    tx_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rx_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL spur_wr_done: ready=%b rx_valid=%b rsp_valid=%b expected 1/0/0", req_ready, rx_valid, rsp_valid);
    end
`ifdef RAM_CMD_MASTER_ERR_CNT_EN
    exp_err += 6;
    checks++;
    if (err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL spur_err_count: got %h expected %h", err_count, 8'(exp_err));
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    int rsp_seen;
    rsp_seen = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (din !== 10'h300) begin
      errors++;
      $display("FAIL rstmid_in_cmd: din=%h expected 300", din);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rx_valid !== 1'b0 || din !== 10'h000 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: rx_valid=%b din=%h busy=%b ready=%b expected 0/000/0/1",
               rx_valid, din, busy, req_ready);
    end
    step();
    rst = 1'b0;
`ifdef RAM_CMD_MASTER_ERR_CNT_EN
    exp_err = 0;
`endif
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_valid === 1'b1) rsp_seen++;
    end
    checks++;
    if (rsp_seen != 0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: rsp_pulses=%0d ready=%b busy=%b expected 0/1/0", rsp_seen, req_ready, busy);
    end
`ifdef RAM_CMD_MASTER_ERR_CNT_EN
    checks++;
    if (err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL rstmid_err_count: got %h expected %h", err_count, 8'(exp_err));
    end
`endif
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h11; req_wdata = 8'h22;
    step();
    // Queue the read while the write is still in flight, req_valid held high.
    req_write = 1'b0; req_addr = 8'h44;
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h011 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_beat0: rx_valid=%b din=%h ready=%b expected 1/011/0", rx_valid, din, req_ready);
    end
    step();
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h122) begin
      errors++;
      $display("FAIL b2b_beat1: rx_valid=%b din=%h expected 1/122", rx_valid, din);
    end
    step();
    checks++;
    if (rx_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: rx_valid=%b ready=%b expected 0/1", rx_valid, req_ready);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h244) begin
      errors++;
      $display("FAIL b2b_beat2: rx_valid=%b din=%h expected 1/244", rx_valid, din);
    end
    step();
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h300) begin
      errors++;
      $display("FAIL b2b_beat3: rx_valid=%b din=%h expected 1/300", rx_valid, din);
    end
    step();
    tx_valid = 1'b1; dout = 8'h99;
    step();
    tx_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h99 || rsp_timeout !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rsp: valid=%b rdata=%h timeout=%b ready=%b expected 1/99/0/1",
               rsp_valid, rsp_rdata, rsp_timeout, req_ready);
    end
    // New request accepted in the same cycle as the read response.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h0F; req_wdata = 8'hF0;
    step();
    req_valid = 1'b0;
    checks++;
    if (rx_valid !== 1'b1 || din !== 10'h00F || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept_on_rsp: rx_valid=%b din=%h rsp_valid=%b expected 1/00f/0", rx_valid, din, rsp_valid);
    end
    step();
    checks++;
    if (din !== 10'h1F0) begin
      errors++;
      $display("FAIL b2b_last_beat: din=%h expected 1f0", din);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(8'h3C, 8'hA5, 2, 1'b1, "read");
    test_read(8'h01, 8'h5A, 1, 1'b1, "read_min");
    test_read(8'h7E, 8'h00, 0, 1'b0, "timeout");
    test_read(8'hFE, 8'hC3, RD_TIMEOUT, 1'b1, "data_wins");
    test_spurious();
    test_reset_mid_read();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
